output_word_packer: RTL
=======================

// Module: output_word_packer
// PURPOSE
//  Sits directly downstream of the accelerator's 16-bit output FIFO. Drains convolution results,
//  packs up to three consecutive 16-bit outputs into one 48-bit bus word, and tags each word with
//  the (x, y, ch) coordinate of its lane-0 element. It feeds the io_bus driver with a valid/ready handshake.
//  Outputs are traversed with x fastest, then y, then ch.
// PARAMETERS
//  FEATURE_MAP_WIDTH   130  max output map width; sets the x counter width $clog2(FEATURE_MAP_WIDTH)
//  FEATURE_MAP_HEIGHT  130  max output map height; sets the y counter width $clog2(FEATURE_MAP_HEIGHT)
//  OUTPUT_NB_CHANNELS  16   output channels per run; sets the ch counter width $clog2(OUTPUT_NB_CHANNELS)
// PORTS
//  clk         in   1    system clock, all logic on the rising edge
//  arst_in     in   1    asynchronous reset, active-high
//  start       in   1    one-cycle pulse; latches cfg_* and begins a run (honoured in IDLE only)
//  cfg_out_w   in   8    output map width for this run (0..FEATURE_MAP_WIDTH)
//  cfg_out_h   in   8    output map height for this run (0..FEATURE_MAP_HEIGHT)
//  in_data     in   16   result word from the output FIFO
//  in_valid    in   1    FIFO not empty
//  in_ready    out  1    pop strobe to the FIFO; a transfer occurs when in_valid && in_ready
//  out_data    out  48   packed word: lane0 = [15:0], lane1 = [31:16], lane2 = [47:32]
//  out_lanes   out  2    number of valid lanes in out_data (1..3)
//  out_x       out  $clog2(FEATURE_MAP_WIDTH)   x of the lane-0 element
//  out_y       out  $clog2(FEATURE_MAP_HEIGHT)  y of the lane-0 element
//  out_ch      out  $clog2(OUTPUT_NB_CHANNELS)  ch of the lane-0 element
//  out_valid   out  1    packed word available
//  out_ready   in   1    consumer accepts; a transfer occurs when out_valid && out_ready
//  busy        out  1    high from the cycle after an accepted start until done
//  done        out  1    one-cycle pulse after the last word transfers
// BEHAVIOUR
//  Reset (async, arst_in=1): state IDLE; all outputs 0; lane buffer, lane count and coordinate counters cleared.
//  Run length: total = cfg_out_w * cfg_out_h * OUTPUT_NB_CHANNELS elements, latched at start.
//  FSM states:
//   IDLE  in_ready=0, busy=0. start -> FILL with counters zeroed.
//         start with w==0 or h==0 -> DONE directly; no words are emitted.
//   FILL  in_ready=1. Each transfer writes in_data into lane[cnt], and cnt increments.
//         Capture the coordinate counters into out_x/out_y/out_ch when cnt==0.
//         Advance x; x wraps to 0 at cfg_out_w-1 and increments y.
//         y wraps to 0 at cfg_out_h-1 and increments ch.
//         Go to SEND when cnt reaches 3, or on the transfer of the last element (partial word).
//   SEND  out_valid=1, in_ready=0. out_data, out_lanes and coordinates are held stable while !out_ready.
//         Unused lanes are 0. Handshake -> clear cnt and lanes.
//         Then go to FILL if elements remain, else DONE.
//   DONE  done=1 for exactly one cycle, busy=0 -> IDLE.
//  Latency: out_valid rises the cycle after the transfer that completes a word.
//         Peak throughput is 3 elements per 4 cycles with out_ready tied high.
//  Throttling: in_valid low in FILL stalls with no state change. An incomplete word is never emitted
//         unless it contains the run's last element.
//  start outside IDLE is ignored; cfg_* changes mid-run have no effect.
//  Element counter is wide enough for the max total (130*130*16), so it cannot overflow.
//  Reset asserted mid-run aborts immediately; buffered elements are discarded and not re-emitted.
// TESTING
//  1 W=3,H=1,ch=16; feed 1..48 -> 16 words; word0 = 0x0003_0002_0001, lanes 3, (0,0,0);
//    word1 has ch=1; done pulses once.
//  2 W=2,H=2,ch=16 (64 elements) -> 22 words; the last word has lanes=1, (1,1,15), upper lanes 0.
//  3 Hold out_ready=0 for 5 cycles during SEND -> out_data and coordinates stable, in_ready=0,
//    no FIFO pops lost.
//  4 start with cfg_out_w=0 -> no out_valid; done pulses 2 cycles after start; busy stays 0.
//  5 Toggle in_valid randomly and assert start while busy -> ignored; word count and contents
//    equal the ungated case.
//  6 Assert arst_in after 2 elements in FILL -> all outputs 0 immediately; a fresh run after reset
//    packs correctly from (0,0,0).

Source files
------------

// File: rtl/output_word_packer.sv
// Drains 16-bit results from the output FIFO and packs up to three consecutive
// elements into a 48-bit bus word tagged with the (x, y, ch) of its lane-0 element.
module output_word_packer #(
  parameter int unsigned FEATURE_MAP_WIDTH  = 130,
  parameter int unsigned FEATURE_MAP_HEIGHT = 130,
  parameter int unsigned OUTPUT_NB_CHANNELS = 16
) (
  input  logic                                  clk,
  input  logic                                  arst_in,
  input  logic                                  start,
  input  logic [7:0]                            cfg_out_w,
  input  logic [7:0]                            cfg_out_h,
  input  logic [15:0]                           in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic [47:0]                           out_data,
  output logic [1:0]                            out_lanes,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  out_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] out_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] out_ch,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  busy,
  output logic                                  done
);

  localparam int unsigned XW        = $clog2(FEATURE_MAP_WIDTH);
  localparam int unsigned YW        = $clog2(FEATURE_MAP_HEIGHT);
  localparam int unsigned CW        = $clog2(OUTPUT_NB_CHANNELS);
  localparam int unsigned MAX_TOTAL = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
  localparam int unsigned TW        = $clog2(MAX_TOTAL + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t         state;
  logic [7:0]     w_q;
  logic [7:0]     h_q;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [CW-1:0]  ch;
  logic [1:0]     cnt;
  logic [TW-1:0]  remaining;

  logic           in_xfer;
  logic           x_wrap;
  logic           y_wrap;
  logic           last_elem;
  logic [TW-1:0]  run_total;

  // Handshake and coordinate-wrap decodes
  always_comb begin
    in_xfer   = in_valid && in_ready;
    x_wrap    = (x == XW'(w_q - 8'd1));
    y_wrap    = (y == YW'(h_q - 8'd1));
    last_elem = (remaining == TW'(1));
    run_total = TW'(cfg_out_w) * TW'(cfg_out_h) * TW'(OUTPUT_NB_CHANNELS);
  end

  // Control FSM with registered outputs; lanes live directly in out_data
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      state     <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      x         <= '0;
      y         <= '0;
      ch        <= '0;
      cnt       <= '0;
      remaining <= '0;
      in_ready  <= 1'b0;
      out_data  <= '0;
      out_lanes <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            w_q       <= cfg_out_w;
            h_q       <= cfg_out_h;
            x         <= '0;
            y         <= '0;
            ch        <= '0;
            cnt       <= '0;
            remaining <= run_total;
            out_data  <= '0;
            out_lanes <= '0;
            if (cfg_out_w == 8'd0 || cfg_out_h == 8'd0) begin
              state <= DONE;
            end else begin
              state    <= FILL;
              in_ready <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end

        FILL: begin
          if (in_xfer) begin
            case (cnt)
              2'd0:    out_data[15:0]  <= in_data;
              2'd1:    out_data[31:16] <= in_data;
              default: out_data[47:32] <= in_data;
            endcase
            if (cnt == 2'd0) begin
              out_x  <= x;
              out_y  <= y;
              out_ch <= ch;
            end
            // x fastest, then y, then ch
            if (x_wrap) begin
              x <= '0;
              if (y_wrap) begin
                y  <= '0;
                ch <= ch + CW'(1);
              end else begin
                y <= y + YW'(1);
              end
            end else begin
              x <= x + XW'(1);
            end
            remaining <= remaining - TW'(1);
            cnt       <= cnt + 2'd1;
            if (cnt == 2'd2 || last_elem) begin
              state     <= SEND;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_lanes <= cnt + 2'd1;
            end
          end
        end

        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lanes <= '0;
            cnt       <= '0;
            if (remaining != '0) begin
              state    <= FILL;
              in_ready <= 1'b1;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
            end
          end
        end

        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
